r4k_ifetch: RTL and testbench
=============================

R4K_IFETCH -- requirements
Module: r4k_ifetch

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch queue depth in entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 64'h0, sets the fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clock clk.
REQ-005 redirect_valid  input  1  core requests a fetch-stream restart (branch/jump taken).
REQ-006 redirect_pc  input  64  restart target.
REQ-007 out_valid  output  1  queue head holds a valid instruction.
REQ-008 out_ready  input  1  decode stage accepts the head this cycle.
REQ-009 out_pc  output  64  address of the head instruction.
REQ-010 out_instr  output  32  head instruction word.
REQ-011 mem_req  output  1  instruction memory read request.
REQ-012 mem_addr  output  64  request address; word aligned.
REQ-013 mem_ack  input  1  single-cycle pulse; the request completes this cycle.
REQ-014 mem_rdata  input  32  read data, valid only while mem_ack=1.
REQ-015 fetch_fault  output  1  misaligned redirect target; present only with the Configuration macro, otherwise tied 0.

Function
REQ-016 The block SHALL hold a fetch pointer (fetch_pc), a circular queue of DEPTH {pc, instr} entries with rd/wr pointers wrapping modulo DEPTH, and a count of 0..DEPTH.
REQ-017 Memory handshake: at most one request outstanding; once raised, mem_req and mem_addr hold stable until the mem_ack cycle; an ack may arrive in the same cycle mem_req rises.
REQ-018 A new request (mem_addr=fetch_pc) SHALL be issued whenever count<DEPTH, no request is outstanding or one completes this cycle, and no fault is pending.
REQ-019 On a non-discarded ack the block SHALL push {mem_addr, mem_rdata} and advance fetch_pc by 4 (64-bit wrap-around); with a zero-wait memory, back-to-back requests SHALL sustain one push per cycle.
REQ-020 Outputs: out_valid=(count!=0); out_pc/out_instr show the head entry; a pop occurs on out_valid&out_ready; a push is visible on outputs in the cycle after the ack (no bypass).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; a push at count=DEPTH cannot occur by construction (REQ-018).
REQ-022 Redirect has top priority: same cycle the queue is flushed (count=0, pointers reset), any pop is ignored, any ack is discarded, and fetch_pc<=redirect_pc; out_valid=0 in the next cycle.
REQ-023 Redirect while a request is outstanding without ack: the request SHALL stay on the bus unchanged until its ack, the ack is discarded, and the request to redirect_pc issues in the cycle following that ack.
REQ-024 A second redirect before the new stream starts SHALL overwrite fetch_pc; only the latest target is fetched.
REQ-025 Redirect latency: with nothing outstanding, mem_req with mem_addr=redirect_pc SHALL assert in the cycle after redirect_valid.

Reset
REQ-026 On reset assertion, the following SHALL take effect immediately: mem_req=0, out_valid=0, fetch_fault=0, queue empty, no outstanding request, discard flag clear, fetch_pc=RESET_PC.
REQ-027 The first request (mem_addr=RESET_PC) SHALL issue in the first clock edge cycle after reset deasserts; an ack arriving during reset is ignored.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request with no discard tracking; the memory side is reset by the same signal.

Configuration
REQ-029 With R4K_IFETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL flush as in REQ-022, set fetch_fault=1, and block new requests; the fault SHALL hold until an aligned redirect, which clears it and resumes fetch.
REQ-030 Without R4K_IFETCH_ALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0 and fetch_fault tied 0.

Verification
REQ-031 Zero-wait memory, out_ready=1 after reset -> out_pc 0,4,8,12 on consecutive cycles starting 2 cycles after reset release, with matching words.
REQ-032 out_ready=0, ack 1 cycle after each req -> exactly 4 pushes, then mem_req stays 0; one pop -> next request issues the following cycle at 0x10.
REQ-033 Redirect to 0x1000 in the same cycle as an ack for 0x8 -> 0x8 data never appears; the next out_pc is 0x1000.
REQ-034 Redirect to 0x2000 while a request for 0x20 is outstanding and ack comes 3 cycles later -> mem_addr holds 0x20 until the ack, which is discarded; the next mem_addr is 0x2000.
REQ-035 With macro defined, redirect to 0x1002 -> fetch_fault=1 and no mem_req; a later redirect to 0x1004 -> fault clears and mem_addr=0x1004. Without the macro, redirect to 0x1002 -> mem_addr=0x1000.
REQ-036 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC -> the next fetch address wraps to 0x0.

Source files
------------

// File: rtl/r4k_ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : r4k_ifetch_if
// Description : Bundles the signals of the instruction fetch unit: the
//               core-side redirect request, the decode-side output stream and
//               the instruction memory read port.
//               master : fetch-unit view (drives out_*, mem_req/addr, fault)
//               slave  : environment view (drives redirect_*, out_ready,
//                        mem_ack/rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface r4k_ifetch_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, out_ready, mem_ack, mem_rdata,
        output out_valid, out_pc, out_instr, mem_req, mem_addr, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, out_ready, mem_ack, mem_rdata,
        input  out_valid, out_pc, out_instr, mem_req, mem_addr, fetch_fault
    );
endinterface
`default_nettype wire

// File: rtl/r4k_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : r4k_ifetch
// Description : Instruction fetch unit with a DEPTH-entry prefetch queue.
//               Issues one word-aligned read at a time, queues {pc, instr}
//               pairs for decode and restarts the stream on redirect.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - r4k_ifetch_if.master (redirect, decode output,
//                        instruction memory read port, fetch_fault)
// Parameters  : DEPTH    - queue depth, power of two, 2..16
//               RESET_PC - first fetch address after reset
// Macro       : R4K_IFETCH_ALIGN_CHECK_EN - when defined, a misaligned
//               redirect target raises fetch_fault and stalls fetch until an
//               aligned redirect; otherwise the target's low bits are cleared
//               and fetch_fault is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module r4k_ifetch #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    r4k_ifetch_if.master    bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    // Architectural state
    logic [63:0]        fetch_pc_q, fetch_pc_d;   // next address to fetch
    logic [63:0]        addr_q,     addr_d;       // address on the bus
    logic               req_q,      req_d;        // request outstanding
    logic               discard_q,  discard_d;    // outstanding ack is stale
    logic               fault_q,    fault_d;
    logic [c_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,    count_d;

    logic [63:0]        pc_mem_q    [DEPTH];
    logic [31:0]        instr_mem_q [DEPTH];

    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic               w_free;
    logic [63:0]        w_target;
    logic               w_target_bad;

`ifdef R4K_IFETCH_ALIGN_CHECK_EN
    assign w_target     = bus.redirect_pc;
    assign w_target_bad = |bus.redirect_pc[1:0];
    assign bus.fetch_fault = fault_q;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^bus.redirect_pc[1:0];
    assign w_target     = {bus.redirect_pc[63:2], 2'b00};
    assign w_target_bad = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    // An ack only counts while a request is actually on the bus.
    assign w_ack  = bus.mem_ack & req_q;
    // A redirect kills both the incoming word and any pop this cycle.
    assign w_push = w_ack & ~discard_q & ~bus.redirect_valid;
    assign w_pop  = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;
    // The bus is available for a new request if idle or completing now.
    assign w_free = ~req_q | w_ack;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = w_target;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fault_d    = w_target_bad;
            // A request still waiting for its ack must be left on the bus;
            // remember to drop its data when it finally completes.
            discard_d  = req_q & ~bus.mem_ack;
        end else begin
            if (w_ack) begin
                discard_d = 1'b0;
            end
            if (w_push) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                wr_ptr_d   = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Issue against the post-update count so the request in flight
        // always has a free slot waiting for it.
        if (w_free) begin
            req_d = 1'b0;
            if (!fault_d && (count_d < c_FULL)) begin
                req_d  = 1'b1;
                addr_d = fetch_pc_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            fault_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= addr_q;
            instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_r4k_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_r4k_ifetch
// Description : Directed self-checking bench for r4k_ifetch. Memory returns
//               ~addr[31:0] as the instruction word, either zero-wait
//               (auto_ack) or on an explicitly driven ack (man_ack).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r4k_ifetch;

    logic clk = 1'b0;
    logic reset;
    logic auto_ack;
    logic man_ack;
    int   n_vec = 0;
    int   n_bad = 0;

    r4k_ifetch_if bus ();

    r4k_ifetch #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.mem_ack   = (auto_ack & bus.mem_req) | man_ack;
        bus.mem_rdata = bus.mem_ack ? ~bus.mem_addr[31:0] : 32'h0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset              = 1'b1;
        auto_ack           = 1'b0;
        man_ack            = 1'b1;   // ack during reset must be ignored
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b0;
        tick;
        tick;
        chk("rst_req",   bus.mem_req,     64'd0);
        chk("rst_valid", bus.out_valid,   64'd0);
        chk("rst_fault", bus.fetch_fault, 64'd0);

        // Zero-wait streaming from RESET_PC
        man_ack       = 1'b0;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        auto_ack      = 1'b1;
        tick;
        chk("first_req",   bus.mem_req,   64'd1);
        chk("first_addr",  bus.mem_addr,  64'h0);
        chk("first_valid", bus.out_valid, 64'd0);
        tick;
        chk("s0_valid", bus.out_valid, 64'd1);
        chk("s0_pc",    bus.out_pc,    64'h0);
        chk("s0_instr", bus.out_instr, 64'hFFFF_FFFF);
        tick;
        chk("s1_pc",    bus.out_pc,    64'h4);
        chk("s1_instr", bus.out_instr, 64'hFFFF_FFFB);
        tick;
        chk("s2_pc",    bus.out_pc,    64'h8);
        chk("s2_instr", bus.out_instr, 64'hFFFF_FFF7);
        tick;
        chk("s3_pc",    bus.out_pc,    64'hC);
        chk("s3_instr", bus.out_instr, 64'hFFFF_FFF3);

        // Asynchronous reset takes effect without a clock edge
        reset = 1'b1;
        #1;
        chk("async_req",   bus.mem_req,   64'd0);
        chk("async_valid", bus.out_valid, 64'd0);
        auto_ack      = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        reset = 1'b0;

        // Fill with ack one cycle after each request, decode stalled
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("fill_req",  bus.mem_req,  64'd1);
            chk("fill_addr", bus.mem_addr, 64'(4 * i));
            tick;
            man_ack = 1'b1;
            tick;
            man_ack = 1'b0;
        end
        chk("full_req",   bus.mem_req,   64'd0);
        chk("full_valid", bus.out_valid, 64'd1);
        chk("full_pc",    bus.out_pc,    64'h0);
        tick;
        chk("full_req2",  bus.mem_req,   64'd0);

        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("pop_req",  bus.mem_req,  64'd1);
        chk("pop_addr", bus.mem_addr, 64'h10);
        chk("pop_pc",   bus.out_pc,   64'h4);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("refull_req", bus.mem_req, 64'd0);
        chk("refull_pc",  bus.out_pc,  64'h4);

        // Redirect with nothing outstanding: request next cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        tick;
        bus.redirect_valid = 1'b0;
        chk("rdlat_req",   bus.mem_req,   64'd1);
        chk("rdlat_addr",  bus.mem_addr,  64'h100);
        chk("rdlat_valid", bus.out_valid, 64'd0);

        // Redirect in the same cycle as the ack for 0x8
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        man_ack = 1'b1;
        tick;
        tick;
        chk("rdack_addr8", bus.mem_addr, 64'h8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1000;
        tick;
        bus.redirect_valid = 1'b0;
        man_ack            = 1'b0;
        chk("rdack_valid", bus.out_valid, 64'd0);
        chk("rdack_req",   bus.mem_req,   64'd1);
        chk("rdack_addr",  bus.mem_addr,  64'h1000);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("rdack_ovalid", bus.out_valid, 64'd1);
        chk("rdack_pc",     bus.out_pc,    64'h1000);
        chk("rdack_instr",  bus.out_instr, 64'hFFFF_EFFF);

        // Redirect to 0x20 while 0x1004 outstanding
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h20;
        tick;
        bus.redirect_valid = 1'b0;
        chk("hold1004_addr",  bus.mem_addr,  64'h1004);
        chk("hold1004_valid", bus.out_valid, 64'd0);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("to20_addr", bus.mem_addr, 64'h20);

        // Redirect to 0x2000, ack for 0x20 arrives three cycles later
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2000;
        tick;
        bus.redirect_valid = 1'b0;
        chk("hold20_a", bus.mem_addr, 64'h20);
        tick;
        chk("hold20_b", bus.mem_addr, 64'h20);
        tick;
        chk("hold20_c", bus.mem_addr, 64'h20);
        chk("hold20_r", bus.mem_req,  64'd1);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("to2000_req",   bus.mem_req,   64'd1);
        chk("to2000_addr",  bus.mem_addr,  64'h2000);
        chk("to2000_valid", bus.out_valid, 64'd0);

        // Two redirects back to back: only the latest is fetched
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h4000;
        tick;
        bus.redirect_pc    = 64'h5000;
        tick;
        bus.redirect_valid = 1'b0;
        chk("dbl_hold", bus.mem_addr, 64'h2000);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("dbl_addr", bus.mem_addr, 64'h5000);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("dbl_valid", bus.out_valid, 64'd1);
        chk("dbl_pc",    bus.out_pc,    64'h5000);
        chk("dbl_instr", bus.out_instr, 64'hFFFF_AFFF);

        // Misaligned redirect target
        man_ack            = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1002;
        tick;
        bus.redirect_valid = 1'b0;
        man_ack            = 1'b0;
`ifdef R4K_IFETCH_ALIGN_CHECK_EN
        chk("mis_fault", bus.fetch_fault, 64'd1);
        chk("mis_req",   bus.mem_req,     64'd0);
        tick;
        chk("mis_fault2", bus.fetch_fault, 64'd1);
        chk("mis_req2",   bus.mem_req,     64'd0);
`else
        chk("mis_fault", bus.fetch_fault, 64'd0);
        chk("mis_req",   bus.mem_req,     64'd1);
        chk("mis_addr",  bus.mem_addr,    64'h1000);
`endif
        man_ack            = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1004;
        tick;
        bus.redirect_valid = 1'b0;
        man_ack            = 1'b0;
        chk("al_fault", bus.fetch_fault, 64'd0);
        chk("al_req",   bus.mem_req,     64'd1);
        chk("al_addr",  bus.mem_addr,    64'h1004);

        // 64-bit wrap of the fetch address
        man_ack            = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        bus.redirect_valid = 1'b0;
        chk("wrap_addr0", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick;
        man_ack = 1'b0;
        chk("wrap_addr",  bus.mem_addr,  64'h0);
        chk("wrap_pc",    bus.out_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", bus.out_instr, 64'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
